// File: rtl/servo_ramp_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : servo_ramp_ctrl
// Description : Command stage for the servo PWM generator. Accepts a target
//               duty through a valid/ready handshake and clamps it to the
//               servo-safe range [DUTY_MIN, DUTY_MAX]. It then slews the duty
//               setpoint toward the target by at most STEP per servo frame.
//               Once the target is reached, it holds for HOLD_FRAMES frames
//               and finally releases enable.
//
// Ports       :
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   cmd_valid   in   a target is offered on cmd_target
//   cmd_ready   out  block can accept a command (IDLE only)
//   cmd_target  in   requested duty, unclamped   [W-1:0]
//   duty        out  registered duty setpoint    [W-1:0]
//   enable      out  PWM enable
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse at the end of HOLD
//   frame_tick  out  one-cycle pulse per servo frame
//
// Revision    : 1.0 - initial release
// ============================================================================
module servo_ramp_ctrl #(
    parameter int FRAME_CYCLES = 1000000,
    parameter int W            = 9,
    parameter int DUTY_MIN     = 50,
    parameter int DUTY_MAX     = 250,
    parameter int STEP         = 4,
    parameter int HOLD_FRAMES  = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [W-1:0] cmd_target,
    output logic [W-1:0] duty,
    output logic         enable,
    output logic         busy,
    output logic         done,
    output logic         frame_tick
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w  = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int c_hold_w = $clog2(HOLD_FRAMES + 1);

    localparam logic [c_cnt_w-1:0]  c_frame_last  = c_cnt_w'(FRAME_CYCLES - 1);
    localparam logic [c_hold_w-1:0] c_hold_frames = c_hold_w'(HOLD_FRAMES);
    localparam logic [W-1:0]        c_duty_min    = W'(DUTY_MIN);
    localparam logic [W-1:0]        c_duty_max    = W'(DUTY_MAX);
    localparam logic [W:0]          c_step        = (W + 1)'(STEP);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_ramp = 2'd1;
    localparam logic [1:0] c_st_hold = 2'd2;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic [c_cnt_w-1:0]  r_frame_cnt;
    logic                r_frame_tick;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [W-1:0]        r_target;
    logic [W-1:0]        r_duty;
    logic                r_active;
    logic                r_cmd_ready;
    logic                r_done;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    logic [c_cnt_w-1:0]  w_frame_nxt;
    logic [W-1:0]        w_clamped;
    logic                w_up;
    logic [W:0]          w_diff;
    logic [W:0]          w_delta;
    logic [W:0]          w_stepped;
    logic                w_reached;
    logic [c_hold_w-1:0] w_hold_inc;

    logic [1:0]          w_state_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [W-1:0]        w_target_nxt;
    logic [W-1:0]        w_duty_nxt;
    logic                w_active_nxt;
    logic                w_ready_nxt;
    logic                w_done_nxt;

    // ------------------------------------------------------------------------
    // Free-running frame counter. frame_tick is registered so that it is high
    // exactly during the cycle in which the counter holds FRAME_CYCLES-1.
    // ------------------------------------------------------------------------
    always_comb begin
        w_frame_nxt = r_frame_cnt + c_cnt_w'(1);
        if (r_frame_cnt == c_frame_last) begin
            w_frame_nxt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt  <= '0;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_cnt  <= w_frame_nxt;
            r_frame_tick <= (w_frame_nxt == c_frame_last);
        end
    end

    // ------------------------------------------------------------------------
    // Target clamping
    // ------------------------------------------------------------------------
    always_comb begin
        w_clamped = cmd_target;
        if (cmd_target < c_duty_min) begin
            w_clamped = c_duty_min;
        end else if (cmd_target > c_duty_max) begin
            w_clamped = c_duty_max;
        end
    end

    // ------------------------------------------------------------------------
    // Slew step. The distance is formed one bit wider than the duty. Both
    // operands lie inside the clamp window, so the sum or difference can never
    // wrap. Comparing the full-width result against the zero-extended target
    // detects the end of the ramp.
    // ------------------------------------------------------------------------
    always_comb begin
        w_up      = (r_target > r_duty);
        w_diff    = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                         : ({1'b0, r_duty}   - {1'b0, r_target});
        w_delta   = (w_diff > c_step) ? c_step : w_diff;
        w_stepped = w_up ? ({1'b0, r_duty} + w_delta)
                         : ({1'b0, r_duty} - w_delta);
        w_reached = (w_stepped == {1'b0, r_target});
    end

    assign w_hold_inc = r_hold_cnt + c_hold_w'(1);

    // ------------------------------------------------------------------------
    // FSM next-state and next-output logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_hold_nxt   = r_hold_cnt;
        w_target_nxt = r_target;
        w_duty_nxt   = r_duty;
        w_done_nxt   = 1'b0;

        case (r_state)
            c_st_idle: begin
                // A frame_tick on the acceptance edge is ignored. Stepping
                // starts at the first tick seen from RAMP.
                if (cmd_valid && r_cmd_ready) begin
                    w_target_nxt = w_clamped;
                    w_hold_nxt   = '0;
                    w_state_nxt  = (w_clamped != r_duty) ? c_st_ramp : c_st_hold;
                end
            end

            c_st_ramp: begin
                // Duty moves only on frame boundaries so that the PWM stage
                // sees a stable value for a whole frame.
                if (r_frame_tick) begin
                    w_duty_nxt = w_stepped[W-1:0];
                    if (w_reached) begin
                        w_state_nxt = c_st_hold;
                        w_hold_nxt  = '0;
                    end
                end
            end

            c_st_hold: begin
                if (r_frame_tick) begin
                    w_hold_nxt = w_hold_inc;
                    if (w_hold_inc == c_hold_frames) begin
                        w_state_nxt = c_st_idle;
                        w_done_nxt  = 1'b1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase

        w_active_nxt = (w_state_nxt != c_st_idle);
        w_ready_nxt  = (w_state_nxt == c_st_idle);
    end

    // ------------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_st_idle;
            r_hold_cnt  <= '0;
            r_target    <= c_duty_min;
            r_duty      <= c_duty_min;
            r_active    <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_cnt  <= w_hold_nxt;
            r_target    <= w_target_nxt;
            r_duty      <= w_duty_nxt;
            r_active    <= w_active_nxt;
            r_cmd_ready <= w_ready_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign duty       = r_duty;
    assign enable     = r_active;
    assign busy       = r_active;
    assign done       = r_done;
    assign frame_tick = r_frame_tick;

endmodule

`default_nettype wire

// File: tb/tb_servo_ramp_ctrl.sv
`timescale 1ns / 1ps
`default_nettype none
// ============================================================================
// Module      : tb_servo_ramp_ctrl
// Description : Self-checking bench for servo_ramp_ctrl. The expected duty
//               after k frames is computed arithmetically from the start
//               duty, the clamped target and STEP. The done pulse is expected
//               after ceil(|target-start|/STEP) + HOLD_FRAMES frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_servo_ramp_ctrl;

    localparam int FC    = 10;
    localparam int W     = 9;
    localparam int DMIN  = 50;
    localparam int DMAX  = 250;
    localparam int STEP  = 4;
    localparam int HOLD  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_target;
    logic [W-1:0] duty;
    logic         enable;
    logic         busy;
    logic         done;
    logic         frame_tick;

    int checks = 0;
    int errors = 0;
    int m_duty = DMIN;

    always #5 clk = ~clk;

    servo_ramp_ctrl #(
        .FRAME_CYCLES (FC),
        .W            (W),
        .DUTY_MIN     (DMIN),
        .DUTY_MAX     (DMAX),
        .STEP         (STEP),
        .HOLD_FRAMES  (HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .duty       (duty),
        .enable     (enable),
        .busy       (busy),
        .done       (done),
        .frame_tick (frame_tick)
    );

    // ---------------- reference model ----------------
    function automatic int clamp(input int t);
        if (t < DMIN) return DMIN;
        if (t > DMAX) return DMAX;
        return t;
    endfunction

    function automatic int duty_after(input int s, input int t, input int k);
        if (t >= s) return (s + k * STEP > t) ? t : s + k * STEP;
        return (s - k * STEP < t) ? t : s - k * STEP;
    endfunction

    function automatic int ramp_frames(input int s, input int t);
        int d;
        d = (t > s) ? t - s : s - t;
        return (d + STEP - 1) / STEP;
    endfunction

    // Observe the tick positions (in negedges after the current one).
    task automatic check_tick_period(input string name);
        int first, second;
        first = -1;
        second = -1;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        checks++;
        if (first != FC - 1 || second != 2 * FC - 1) begin
            errors++;
            $display("FAIL %s: ticks at %0d,%0d expected %0d,%0d",
                     name, first, second, FC - 1, 2 * FC - 1);
        end
    endtask

    task automatic check_idle_outputs(input string name, input int exp_duty);
        checks++;
        if (duty !== W'(exp_duty) || enable !== 1'b0 || cmd_ready !== 1'b1 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL %s: duty=%0d en=%b rdy=%b busy=%b done=%b expected duty=%0d en=0 rdy=1 busy=0 done=0",
                     name, duty, enable, cmd_ready, busy, done, exp_duty);
        end
    endtask

    // Issue one command (unless it was already accepted on the current edge)
    // and follow it until the done pulse, checking every cycle.
    task automatic run_cmd(input int req, input bit pre_accepted, input bit persist,
                           input int persist_target, input string name);
        int s, t, n, ticks, exp;
        bit finished;
        s = m_duty;
        t = clamp(req);
        n = ramp_frames(s, t) + HOLD;
        if (!pre_accepted) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            checks++;
            if (cmd_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_before: cmd_ready=%b expected 1", name, cmd_ready);
            end
            cmd_valid  = 1'b1;
            cmd_target = W'(req);
        end
        ticks = 0;
        finished = 1'b0;
        for (int cyc = 0; cyc < 3000 && !finished; cyc++) begin
            @(negedge clk);
            if (cyc == 0) begin
                cmd_valid  = persist;
                cmd_target = W'(persist_target);
            end
            checks++;
            if (ticks == n) begin
                if (done !== 1'b1 || enable !== 1'b0 || cmd_ready !== 1'b1 ||
                    busy !== 1'b0 || duty !== W'(t)) begin
                    errors++;
                    $display("FAIL %s end: done=%b en=%b rdy=%b busy=%b duty=%0d expected 1 0 1 0 %0d",
                             name, done, enable, cmd_ready, busy, duty, t);
                end
                finished = 1'b1;
            end else begin
                exp = duty_after(s, t, ticks);
                if (done !== 1'b0 || enable !== 1'b1 || cmd_ready !== 1'b0 ||
                    busy !== 1'b1 || duty !== W'(exp)) begin
                    errors++;
                    $display("FAIL %s frame %0d cyc %0d: done=%b en=%b rdy=%b busy=%b duty=%0d expected 0 1 0 1 %0d",
                             name, ticks, cyc, done, enable, cmd_ready, busy, duty, exp);
                end
                if (frame_tick === 1'b1) ticks++;
            end
        end
        if (!finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: done never seen, frames=%0d expected %0d", name, ticks, n);
        end
        m_duty = t;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int waited;
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset_values", DMIN);
        checks++;
        if (frame_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_tick: frame_tick=%b expected 0", frame_tick);
        end
        reset = 1'b0;
        check_tick_period("tick_period");
        // reset landing on a tick cycle restarts the counter
        waited = 0;
        while (frame_tick !== 1'b1 && waited < 3 * FC) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (frame_tick !== 1'b1) begin
            errors++;
            $display("FAIL tick_wait: frame_tick=%b expected 1", frame_tick);
        end
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset_on_tick", DMIN);
        reset = 1'b0;
        check_tick_period("tick_after_reset");
        m_duty = DMIN;
    endtask

    task automatic test_ramp_up();
        run_cmd(62, 1'b0, 1'b0, 0, "ramp_up");
        @(negedge clk);
        check_idle_outputs("ramp_up_done_one_cycle", 62);
    endtask

    task automatic test_ramp_down();
        run_cmd(55, 1'b0, 1'b0, 0, "ramp_down_partial");
    endtask

    task automatic test_clamp();
        run_cmd(300, 1'b0, 1'b0, 0, "clamp_high");
        run_cmd(10, 1'b0, 1'b0, 0, "clamp_low");
        run_cmd(50, 1'b0, 1'b0, 0, "no_move");
        @(negedge clk);
        check_idle_outputs("no_move_after", DMIN);
    endtask

    task automatic test_busy_ignore();
        // cmd_valid/200 stays high through the whole busy period
        run_cmd(80, 1'b0, 1'b1, 200, "busy_ignore");
        run_cmd(200, 1'b1, 1'b0, 0, "busy_accept_first_idle");
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_cmd(int'($urandom_range(0, 511)), 1'b0, 1'b0, 0, "random");
        end
    endtask

    task automatic test_reset_mid_ramp();
        int ticks;
        bit bad;
        reset = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
        cmd_valid  = 1'b1;
        cmd_target = W'(100);
        @(negedge clk);
        cmd_valid = 1'b0;
        ticks = 0;
        for (int cyc = 0; cyc < 10 * FC && ticks < 2; cyc++) begin
            if (frame_tick === 1'b1) ticks++;
            if (ticks < 2) @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (duty !== W'(58) || busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_ramp_pre: duty=%0d busy=%b expected 58 1", duty, busy);
        end
        reset = 1'b1;
        @(negedge clk);
        check_idle_outputs("mid_ramp_reset", DMIN);
        reset = 1'b0;
        bad = 1'b0;
        for (int cyc = 0; cyc < 4 * FC; cyc++) begin
            @(negedge clk);
            if (duty !== W'(DMIN) || done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL mid_ramp_no_resume: duty=%0d done=%b busy=%b expected 50 0 0",
                     duty, done, busy);
        end
        m_duty = DMIN;
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_clamp();
        test_busy_ignore();
        test_random();
        test_reset_mid_ramp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
